// File: rtl/mor1kx_trace_stm_decoder.sv
// Decodes l.nop trace markers from the mor1kx execution trace into timestamped
// (id, value) events, buffered in a small FIFO with in-band lost-event records.

package opensocdebug;
   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] pc;
      logic        valid;
      logic [31:0] wbdata;
      logic [4:0]  wbreg;
      logic        wben;
   } mor1kx_trace_exec;
endpackage

module mor1kx_trace_stm_decoder #(
   parameter int          FIFO_DEPTH = 4,
   parameter int          TS_WIDTH   = 32,
   parameter logic [15:0] ID_MIN     = 16'h0004
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  opensocdebug::mor1kx_trace_exec trace_port,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [15:0]                   out_id,
   output logic [31:0]                   out_value,
   output logic [TS_WIDTH-1:0]           out_timestamp
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [15:0]         id;
      logic [31:0]         value;
      logic [TS_WIDTH-1:0] ts;
   } entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   state_t              state_r, state_next_s;
   entry_t              mem_r [FIFO_DEPTH];
   logic [AW-1:0]       rd_ptr_r, wr_ptr_r, rd_ptr_next_s, wr_ptr_next_s;
   logic [CW-1:0]       count_r, count_next_s;
   logic [31:0]         lost_r, lost_next_s;
   logic [31:0]         r3_r, r3_fwd_s;
   logic [TS_WIDTH-1:0] ts_r;
   logic                r3_wr_s, evt_s, pop_s, push_ok_s, push_s;
   entry_t              push_entry_s, head_next_s;
   logic                out_valid_r;
   logic [15:0]         out_id_r;
   logic [31:0]         out_value_r;
   logic [TS_WIDTH-1:0] out_ts_r;
   logic                unused_s;

   assign unused_s = ^{trace_port.pc, trace_port.insn[23:16]};

   // Event detection, overflow-record arbitration and FIFO bookkeeping
   always_comb begin
      r3_wr_s      = trace_port.valid && trace_port.wben && (trace_port.wbreg == 5'd3);
      r3_fwd_s     = r3_wr_s ? trace_port.wbdata : r3_r;
      evt_s        = trace_port.valid && (trace_port.insn[31:24] == 8'h15) &&
                     (trace_port.insn[15:0] >= ID_MIN);
      pop_s        = out_valid_r && out_ready;
      push_ok_s    = (state_r != ST_FULL) || pop_s;
      push_s       = 1'b0;
      push_entry_s = '0;
      lost_next_s  = lost_r;

      // A pending loss report takes the free slot ahead of any new event
      if ((lost_r != 32'd0) && push_ok_s) begin
         push_s       = 1'b1;
         push_entry_s = '{id: 16'h0000, value: lost_r, ts: ts_r};
         lost_next_s  = evt_s ? 32'd1 : 32'd0;
      end else if (evt_s) begin
         if (push_ok_s) begin
            push_s       = 1'b1;
            push_entry_s = '{id: trace_port.insn[15:0], value: r3_fwd_s, ts: ts_r};
         end else begin
            lost_next_s = sat_inc(lost_r);
         end
      end else begin
         lost_next_s = lost_r;
      end

      rd_ptr_next_s = pop_s  ? rd_ptr_r + AW'(1) : rd_ptr_r;
      wr_ptr_next_s = push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;

      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CW'(1);
         2'b01:   count_next_s = count_r - CW'(1);
         default: count_next_s = count_r;
      endcase

      if (count_next_s == CW'(0)) begin
         state_next_s = ST_EMPTY;
      end else if (count_next_s == CW'(FIFO_DEPTH)) begin
         state_next_s = ST_FULL;
      end else begin
         state_next_s = ST_PARTIAL;
      end

      // The new head may be the entry being written this very cycle
      if (push_s && (rd_ptr_next_s == wr_ptr_r)) begin
         head_next_s = push_entry_s;
      end else begin
         head_next_s = mem_r[rd_ptr_next_s];
      end
   end

   // FIFO storage, pointers, state, lost counter, r3 shadow and timestamp
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         state_r  <= ST_EMPTY;
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
         lost_r   <= 32'd0;
         r3_r     <= 32'd0;
         ts_r     <= '0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= push_entry_s;
         end
         state_r  <= state_next_s;
         rd_ptr_r <= rd_ptr_next_s;
         wr_ptr_r <= wr_ptr_next_s;
         count_r  <= count_next_s;
         lost_r   <= lost_next_s;
         if (r3_wr_s) begin
            r3_r <= trace_port.wbdata;
         end
         ts_r <= ts_r + TS_WIDTH'(1);
      end
   end

   // Registered copy of the FIFO head for the packetizer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_id_r    <= 16'h0000;
         out_value_r <= 32'd0;
         out_ts_r    <= '0;
      end else begin
         out_valid_r <= (state_next_s != ST_EMPTY);
         out_id_r    <= head_next_s.id;
         out_value_r <= head_next_s.value;
         out_ts_r    <= head_next_s.ts;
      end
   end

   assign out_valid     = out_valid_r;
   assign out_id        = out_id_r;
   assign out_value     = out_value_r;
   assign out_timestamp = out_ts_r;

endmodule

// File: doc/mor1kx_trace_stm_decoder.md
# mor1kx_trace_stm_decoder

Consumer-side decoder for the mor1kx execution trace port (`opensocdebug::mor1kx_trace_exec`). Watches retired instructions, tracks the architectural value of r3, and converts software trace markers (`l.nop K`) into timestamped (id, value) events. Events are buffered in a small FIFO and handed to the System Trace Module packetizer over a valid/ready interface. Lost events are accounted and reported in-band.

## Interface
- FIFO_DEPTH, 4, event buffer entries; power of two, ≥2
- TS_WIDTH, 32, timestamp counter width
- ID_MIN, 16'h0004, smallest `l.nop` immediate treated as a trace event
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- trace_port  in  struct  `opensocdebug::mor1kx_trace_exec` {insn, pc, valid, wbdata, wbreg, wben}
- out_valid  out  1  event available
- out_ready  in  1  packetizer accepts event
- out_id  out  16  event id; 16'h0000 = overflow record
- out_value  out  32  r3 value, or lost-event count for overflow records
- out_timestamp  out  TS_WIDTH  cycle timestamp of event

## Operation
- Timestamp counter: +1 every cycle, wraps to 0 at 2^TS_WIDTH−1; reset 0.
- r3 shadow: on `valid && wben && wbreg==5'd3` load `wbdata`; reset 0.
- Event detect: `valid && insn[31:24]==8'h15 && insn[15:0] >= ID_MIN`. id = `insn[15:0]`; value = r3 shadow, forwarded from `wbdata` if same-cycle r3 write; timestamp = counter value that cycle.
- Non-matching instructions, `valid==0`, `l.nop K` with K<ID_MIN: no effect besides r3 tracking.
- FIFO: FIFO_DEPTH entries of {id, value, timestamp}, in-order. Push permitted when `count < FIFO_DEPTH` or a pop occurs same cycle.
- Lost counter (32 bit, saturates at 32'hFFFF_FFFF, reset 0): increments when an event is detected but cannot be pushed.
- Overflow record priority: if lost ≠ 0 and push permitted, push {id 16'h0000, value = lost, ts = current counter} and clear lost. A trace event detected in that same cycle is not pushed; lost becomes 1.
- Otherwise detected events are pushed directly.
- Pop: `out_valid && out_ready`. Outputs present FIFO head; stable while `out_valid && !out_ready`.
- States: EMPTY (count 0), PARTIAL, FULL (count = FIFO_DEPTH); transitions solely by push/pop per cycle; push+pop leaves count unchanged.

## Timing
- Reset (asynchronous, rst_n low): out_valid 0, out_id 0, out_value 0, out_timestamp 0, FIFO count 0, pointers 0, lost 0, r3 shadow 0, timestamp 0. Effective immediately, mid-transfer included; in-flight events discarded.
- Latency: event detected in cycle N → out_valid high in cycle N+1 (registered outputs) when FIFO was empty.
- Throughput: one event per cycle sustained with out_ready held high.
- FULL with simultaneous pop: new event accepted, no loss.
- FULL without pop: event lost, lost counter increments in same cycle.
- Timestamp wrap: recorded value is raw counter; no wrap flag.
- out_valid never depends combinationally on out_ready.

## Test plan
- Basic event: r3 write 32'hDEADBEEF, later `l.nop 0x0010` (insn 32'h15000010) at counter 100 → next cycle out_valid=1, out_id=16'h0010, out_value=32'hDEADBEEF, out_timestamp=100.
- Filtering: `l.nop 0x0001`, non-nop insns, and `valid=0` cycles with matching insn → out_valid stays 0; r3 writes with wbreg≠3 leave shadow unchanged.
- Forwarding: cycle with `wben=1, wbreg=3, wbdata=32'h1234` and matching nop insn → event value 32'h1234.
- Overflow: out_ready=0, issue 6 events with FIFO_DEPTH=4 → 4 events held, lost=2; raise out_ready, no new events → 4 events in order then record id 0, value 2.
- Backpressure stability: toggle out_ready randomly under back-to-back events → no reorder, no duplication, head fields constant while stalled; full+pop cycle loses nothing.
- Async reset mid-stream: assert rst_n low with 3 events queued → out_valid, out_id, out_value, out_timestamp drop to 0 without clock edge; after release timestamp restarts at 0.
